// File: rtl/vram_arbiter.sv
// Single-port frame-memory arbiter: scan-out reads win, buffered pixel writes and a
// full-screen clear engine use blanking cycles. Optional write clipping: VRAM_ARB_CLIP_EN.
module vram_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int H_RES      = 640,
   parameter int V_RES      = 480
) (
   input  logic        pix_clk,
   input  logic        rst,
   input  logic [11:0] pix_x,
   input  logic [11:0] pix_y,
   input  logic        pix_valid,
   output logic [11:0] pix_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [11:0] wr_x,
   input  logic [11:0] wr_y,
   input  logic [11:0] wr_data,
   output logic        wr_err,
   input  logic        clr_req,
   input  logic [11:0] clr_color,
   output logic        clr_busy,
   output logic        mem_en,
   output logic        mem_we,
   output logic [18:0] mem_addr,
   output logic [11:0] mem_din,
   input  logic [11:0] mem_dout
);

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [18:0] LAST_ADDR = 19'(H_RES * V_RES - 1);

   function automatic logic [18:0] addr_of(input logic [11:0] x, input logic [11:0] y);
      logic [18:0] yy;
      yy = {7'd0, y};
      if (H_RES == 640)
         return (yy << 9) + (yy << 7) + {7'd0, x};
      else
         return 19'(yy * 19'(H_RES)) + {7'd0, x};
   endfunction

   typedef enum logic {IDLE, RUN} clr_state_t;

   clr_state_t  state_reg, state_next;
   logic [18:0] clr_cnt_reg, clr_cnt_next;
   logic [11:0] clr_color_reg, clr_color_next;
   logic        clr_own;

   logic [30:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          fifo_empty, fifo_full;
   logic          push, pop;
   logic [30:0]   head;
   logic          pix_valid_reg;

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == (AW+1)'(FIFO_DEPTH));
   assign wr_ready   = !fifo_full;
   assign head       = fifo_mem[rd_ptr_reg];
   assign clr_busy   = (state_reg == RUN);

`ifdef VRAM_ARB_CLIP_EN
   logic in_range, wr_err_reg;
   assign in_range = (wr_x < 12'(H_RES)) && (wr_y < 12'(V_RES));
   assign push     = wr_valid && wr_ready && in_range;
   assign wr_err   = wr_err_reg;

   // Out-of-range writes are acknowledged but dropped, flagged one cycle later.
   always_ff @(posedge pix_clk) begin
      if (rst) wr_err_reg <= 1'b0;
      else     wr_err_reg <= wr_valid && wr_ready && !in_range;
   end
`else
   assign push   = wr_valid && wr_ready;
   assign wr_err = 1'b0;
`endif

   // Port ownership: scan-out, then clear engine, then FIFO head, else idle.
   always_comb begin
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      clr_own  = 1'b0;
      pop      = 1'b0;
      if (pix_valid) begin
         mem_en   = 1'b1;
         mem_addr = addr_of(pix_x, pix_y);
      end else if (state_reg == RUN) begin
         mem_en   = 1'b1;
         mem_we   = 1'b1;
         mem_addr = clr_cnt_reg;
         mem_din  = clr_color_reg;
         clr_own  = 1'b1;
      end else if (!fifo_empty) begin
         mem_en   = 1'b1;
         mem_we   = 1'b1;
         mem_addr = head[30:12];
         mem_din  = head[11:0];
         pop      = 1'b1;
      end
   end

   always_comb begin
      state_next     = state_reg;
      clr_cnt_next   = clr_cnt_reg;
      clr_color_next = clr_color_reg;
      case (state_reg)
         IDLE: begin
            if (clr_req) begin
               state_next     = RUN;
               clr_cnt_next   = '0;
               clr_color_next = clr_color;
            end
         end
         RUN: begin
            if (clr_own) begin
               if (clr_cnt_reg == LAST_ADDR) state_next = IDLE;
               else                          clr_cnt_next = clr_cnt_reg + 19'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge pix_clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         clr_cnt_reg   <= '0;
         clr_color_reg <= '0;
      end else begin
         state_reg     <= state_next;
         clr_cnt_reg   <= clr_cnt_next;
         clr_color_reg <= clr_color_next;
      end
   end

   // Storage has no reset; validity is tracked solely by the pointers and count.
   always_ff @(posedge pix_clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= {addr_of(wr_x, wr_y), wr_data};
   end

   always_ff @(posedge pix_clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge pix_clk) begin
      if (rst) pix_valid_reg <= 1'b0;
      else     pix_valid_reg <= pix_valid;
   end

   assign pix_data = pix_valid_reg ? mem_dout : 12'h000;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency frame memory.
// A reduced V_RES keeps a full clear short; H_RES stays at 640.
module tb_vram_arbiter;

   localparam int H = 640;
   localparam int V = 8;

   logic        pix_clk = 1'b0;
   logic        rst;
   logic [11:0] pix_x, pix_y;
   logic        pix_valid;
   logic [11:0] pix_data;
   logic        wr_valid, wr_ready;
   logic [11:0] wr_x, wr_y, wr_data;
   logic        wr_err;
   logic        clr_req;
   logic [11:0] clr_color;
   logic        clr_busy;
   logic        mem_en, mem_we;
   logic [18:0] mem_addr;
   logic [11:0] mem_din;
   logic [11:0] mem_dout;

   logic [11:0] vram [0:8191];

   int n_vec = 0;
   int n_err = 0;

   always #5 pix_clk = ~pix_clk;

   vram_arbiter #(.FIFO_DEPTH(4), .H_RES(H), .V_RES(V)) dut (
      .pix_clk(pix_clk), .rst(rst),
      .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pix_data(pix_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
      .wr_data(wr_data), .wr_err(wr_err),
      .clr_req(clr_req), .clr_color(clr_color), .clr_busy(clr_busy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout)
   );

   // Read-first synchronous frame memory
   always @(posedge pix_clk) begin
      if (mem_en) begin
         mem_dout <= vram[mem_addr[12:0]];
         if (mem_we) vram[mem_addr[12:0]] <= mem_din;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge pix_clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n, exp_cnt, errs;
      logic [18:0] last_addr;

      for (int i = 0; i < 8192; i++) vram[i] = 12'(i);
      mem_dout  = 12'h000;
      rst = 1'b1; pix_x = '0; pix_y = '0; pix_valid = 1'b0;
      wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
      clr_req = 1'b0; clr_color = '0;

      // Reset values
      adv(); adv();
      @(negedge pix_clk);
      chk("rst_clr_busy", 32'(clr_busy), 0);
      chk("rst_wr_err", 32'(wr_err), 0);
      chk("rst_pix_data", 32'(pix_data), 0);
      chk("rst_wr_ready", 32'(wr_ready), 1);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_din", 32'(mem_din), 0);
      adv(); rst = 1'b0;

      // Scan-out read at (3,2)
      pix_valid = 1'b1; pix_x = 12'd3; pix_y = 12'd2;
      @(negedge pix_clk);
      chk("scan_en", 32'(mem_en), 1);
      chk("scan_we", 32'(mem_we), 0);
      chk("scan_addr", 32'(mem_addr), 1283);
      adv(); pix_valid = 1'b0;
      @(negedge pix_clk);
      chk("scan_pix_data", 32'(pix_data), 32'h503);
      adv();
      @(negedge pix_clk);
      chk("blank_pix_data", 32'(pix_data), 0);
      adv();

      // Push during active video, written on first blanking cycle
      pix_valid = 1'b1; pix_x = '0; pix_y = '0;
      wr_valid = 1'b1; wr_x = 12'd10; wr_y = 12'd1; wr_data = 12'hF00;
      @(negedge pix_clk);
      chk("act_push_we", 32'(mem_we), 0);
      adv(); wr_valid = 1'b0;
      @(negedge pix_clk);
      chk("act_hold_we", 32'(mem_we), 0);
      adv(); pix_valid = 1'b0;
      @(negedge pix_clk);
      chk("blank_wr_we", 32'(mem_we), 1);
      chk("blank_wr_addr", 32'(mem_addr), 650);
      chk("blank_wr_din", 32'(mem_din), 32'hF00);
      adv();
      @(negedge pix_clk);
      chk("fifo_idle_en", 32'(mem_en), 0);
      adv();

      // Five pushes into a 4-deep FIFO during active video
      pix_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1; wr_x = 12'(i); wr_y = 12'd3; wr_data = 12'hA00 + 12'(i);
         @(negedge pix_clk);
         chk("fill_ready", 32'(wr_ready), (i < 4) ? 1 : 0);
         adv();
      end
      wr_valid = 1'b0; pix_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge pix_clk);
         chk("drain_we", 32'(mem_we), 1);
         chk("drain_addr", 32'(mem_addr), 1920 + i);
         chk("drain_din", 32'(mem_din), 32'hA00 + 32'(i));
         adv();
      end
      @(negedge pix_clk);
      chk("drain_ready", 32'(wr_ready), 1);
      chk("drain_idle_en", 32'(mem_en), 0);
      adv();

      // Clear to green with a push in the same cycle
      clr_req = 1'b1; clr_color = 12'h0F0;
      wr_valid = 1'b1; wr_x = 12'd5; wr_y = 12'd2; wr_data = 12'hABC;
      @(negedge pix_clk);
      chk("clr_req_busy", 32'(clr_busy), 0);
      adv(); clr_req = 1'b0; wr_valid = 1'b0; clr_color = 12'h000;
      n = 0; exp_cnt = 0; errs = 0; last_addr = '0;
      while (clr_busy && n < 20000) begin
         pix_valid = ((n % 50) < 5);
         @(negedge pix_clk);
         if (!pix_valid) begin
            if (!(mem_we && mem_addr == 19'(exp_cnt) && mem_din == 12'h0F0)) errs++;
            last_addr = mem_addr;
            exp_cnt++;
         end else if (mem_we) begin
            errs++;
         end
         adv();
         n++;
      end
      pix_valid = 1'b0;
      chk("clr_timeout", 32'(n < 20000), 1);
      chk("clr_seq_errs", 32'(errs), 0);
      chk("clr_writes", 32'(exp_cnt), H * V);
      chk("clr_last_addr", 32'(last_addr), H * V - 1);
      @(negedge pix_clk);
      chk("post_clr_busy", 32'(clr_busy), 0);
      chk("post_clr_we", 32'(mem_we), 1);
      chk("post_clr_addr", 32'(mem_addr), 1285);
      chk("post_clr_din", 32'(mem_din), 32'hABC);
      adv();
      pix_valid = 1'b1; pix_x = 12'd5; pix_y = 12'd2;
      adv(); pix_x = 12'd6;
      @(negedge pix_clk);
      chk("rb_written", 32'(pix_data), 32'hABC);
      adv(); pix_valid = 1'b0;
      @(negedge pix_clk);
      chk("rb_green", 32'(pix_data), 32'h0F0);
      adv();

      // Out-of-range push (640,0)
      wr_valid = 1'b1; wr_x = 12'd640; wr_y = 12'd0; wr_data = 12'h123;
      @(negedge pix_clk);
      chk("oor_ready", 32'(wr_ready), 1);
      adv(); wr_valid = 1'b0;
      @(negedge pix_clk);
`ifdef VRAM_ARB_CLIP_EN
      chk("oor_err", 32'(wr_err), 1);
      chk("oor_no_write", 32'(mem_en), 0);
      adv();
      @(negedge pix_clk);
      chk("oor_err_pulse", 32'(wr_err), 0);
`else
      chk("oor_err", 32'(wr_err), 0);
      chk("oor_we", 32'(mem_we), 1);
      chk("oor_addr", 32'(mem_addr), 640);
      chk("oor_din", 32'(mem_din), 32'h123);
`endif
      adv();

      // Reset mid-clear at counter 1000 with pending FIFO entries
      clr_req = 1'b1; clr_color = 12'h00F;
      adv(); clr_req = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         wr_valid = (k < 2); wr_x = 12'(k); wr_y = 12'd4; wr_data = 12'h777;
         adv();
      end
      wr_valid = 1'b0;
      rst = 1'b1;
      @(negedge pix_clk);
      chk("mid_clr_addr", 32'(mem_addr), 1000);
      chk("mid_clr_busy", 32'(clr_busy), 1);
      adv(); rst = 1'b0;
      @(negedge pix_clk);
      chk("rst_mid_busy", 32'(clr_busy), 0);
      chk("rst_mid_en", 32'(mem_en), 0);
      chk("rst_mid_ready", 32'(wr_ready), 1);
      adv();
      @(negedge pix_clk);
      chk("rst_fifo_empty", 32'(mem_en), 0);
      adv();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
